// File: rtl/sm4_rk_buffer.sv
// SM4 round-key buffer: stores rk[0..31] from key expansion and replays them
// ascending (encrypt) or descending (decrypt). Optional macro: SM4_RK_ZEROIZE_EN.
module sm4_rk_buffer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned RK_NUM     = 32,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SM4_RK_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  input  logic                  key_load,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_rk,
  output logic                  wr_ready,
  output logic                  key_ready,
  input  logic                  rd_start,
  input  logic                  rd_mode,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_rk,
  output logic [IDX_WIDTH-1:0]  rd_idx,
  input  logic                  rd_ready,
  output logic                  rd_done
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(RK_NUM - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StKeysValid, StRead} state_e;

  state_e                state;
  logic [IDX_WIDTH-1:0]  wr_cnt;
  logic [IDX_WIDTH-1:0]  rd_ptr;
  logic                  dec_mode;
  logic [WORD_WIDTH-1:0] mem [RK_NUM];

  logic                  clr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [IDX_WIDTH-1:0]  start_ptr;
  logic [IDX_WIDTH-1:0]  next_ptr;

`ifdef SM4_RK_ZEROIZE_EN
  assign clr = zeroize | key_load;
`else
  assign clr = key_load;
`endif

  assign wr_ready  = (state == StIdle) || (state == StLoad);
  assign key_ready = (state == StKeysValid) || (state == StRead);
  assign wr_fire   = wr_valid & wr_ready & ~clr;
  assign rd_fire   = rd_valid & rd_ready;
  assign start_ptr = rd_mode ? LastIdx : '0;
  assign next_ptr  = dec_mode ? (rd_ptr - 1'b1) : (rd_ptr + 1'b1);

  // Key storage: no reset unless zeroization is built in.
`ifdef SM4_RK_ZEROIZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RK_NUM); i++) mem[i] <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < int'(RK_NUM); i++) mem[i] <= '0;
    end else if (wr_fire) begin
      mem[wr_cnt] <= wr_rk;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_cnt] <= wr_rk;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      dec_mode <= 1'b0;
      rd_valid <= 1'b0;
      rd_rk    <= '0;
      rd_idx   <= '0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (clr) begin
        // Abort everything; a same-cycle write beat was already masked off.
        state    <= StIdle;
        wr_cnt   <= '0;
        rd_valid <= 1'b0;
      end else begin
        case (state)
          StIdle, StLoad: begin
            if (wr_valid) begin
              if (wr_cnt == LastIdx) begin
                wr_cnt <= '0;
                state  <= StKeysValid;
              end else begin
                wr_cnt <= wr_cnt + 1'b1;
                state  <= StLoad;
              end
            end
          end
          StKeysValid: begin
            if (rd_start) begin
              dec_mode <= rd_mode;
              rd_ptr   <= start_ptr;
              rd_rk    <= mem[start_ptr];
              rd_idx   <= '0;
              rd_valid <= 1'b1;
              state    <= StRead;
            end
          end
          StRead: begin
            if (rd_fire) begin
              if (rd_idx == LastIdx) begin
                rd_valid <= 1'b0;
                rd_done  <= 1'b1;
                state    <= StKeysValid;
              end else begin
                rd_ptr <= next_ptr;
                rd_rk  <= mem[next_ptr];
                rd_idx <= rd_idx + 1'b1;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/sm4_rk_buffer.md
Name: sm4_rk_buffer

Overview:
- Round-key store between the SM4 key-expansion datapath (writer) and the round datapath (reader).
- Accepts the 32 round keys rk[0..31] in generation order over a valid/ready write port.
- Serves them back over a valid/ready read port:
  - ascending order for encryption;
  - descending order (rk[31]..rk[0]) for decryption.
- Keys are retained, so repeated read passes need no re-expansion.

Parameters:
WORD_WIDTH  32  round-key width in bits
RK_NUM      32  number of round keys stored
IDX_WIDTH   5   width of round/pointer counters (log2 RK_NUM)

Ports:
clk        input   1           clock, rising edge
rst_n      input   1           asynchronous active-low reset
key_load   input   1           pulse: invalidate stored keys, restart write at index 0
wr_valid   input   1           write beat valid
wr_rk      input   WORD_WIDTH  round key being written
wr_ready   output  1           buffer accepts write beat
key_ready  output  1           all RK_NUM keys stored and valid
rd_start   input   1           pulse: begin one read pass
rd_mode    input   1           0 = encrypt (ascending), 1 = decrypt (descending); sampled with rd_start
rd_valid   output  1           rd_rk holds a valid key
rd_rk      output  WORD_WIDTH  round key for current round
rd_idx     output  IDX_WIDTH   round number 0..31 of current beat (always ascending)
rd_ready   input   1           consumer accepts current beat
rd_done    output  1           one-cycle pulse after last read beat

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, wr_cnt 0, rd_ptr 0, wr_ready 1, key_ready 0, rd_valid 0, rd_rk 0, rd_idx 0, rd_done 0.
- States:
  - IDLE: empty.
  - LOAD: partially written.
  - KEYS_VALID: full, not reading.
  - READ: pass in progress.
- Outputs decoded from state:
  - wr_ready = (IDLE or LOAD).
  - key_ready = (KEYS_VALID or READ).
- Write:
  - A beat transfers when wr_valid & wr_ready: mem[wr_cnt] <= wr_rk, wr_cnt++.
  - The first transfer moves IDLE -> LOAD.
  - The transfer with wr_cnt == RK_NUM-1 moves to KEYS_VALID; wr_cnt wraps to 0. wr_ready is low from the next cycle.
  - wr_valid while wr_ready is low is ignored (no write, no error).
- key_load:
  - Takes effect in any state: wr_cnt <= 0 and state <= IDLE on the next edge.
  - key_ready, rd_valid and rd_done are low from the next cycle; an active read pass is aborted.
  - Has priority over a same-cycle write beat, rd_start or read transfer; the write beat is discarded.
- rd_start:
  - Honoured only in KEYS_VALID; ignored in IDLE, LOAD and READ.
  - On the accepting edge: latch rd_mode; rd_ptr <= 0 (enc) or RK_NUM-1 (dec); rd_rk <= mem[start ptr]; rd_idx <= 0; rd_valid <= 1; state <= READ.
  - Latency: rd_start in cycle t gives the first key on rd_rk in cycle t+1.
- Read handshake:
  - A beat transfers when rd_valid & rd_ready.
  - On transfer: rd_ptr steps ±1 per latched mode; rd_rk <= mem[next ptr]; rd_idx++ (registered, no bubbles). Back-to-back transfers run every cycle.
  - While rd_ready is low, rd_rk and rd_idx hold stable.
- End of pass:
  - The transfer with rd_idx == RK_NUM-1 sets rd_valid <= 0 and rd_done <= 1 for exactly one cycle; state returns to KEYS_VALID.
  - A new rd_start is accepted in the cycle rd_done is high.
- Pointer arithmetic is modulo 2^IDX_WIDTH. Pointers never leave 0..RK_NUM-1 within a pass.
- Storage array is not reset (overwritten only by writes), except as noted under the optional feature.
- Reset asserted mid-load or mid-read returns to the reset values immediately (asynchronously). The stored array content is then undefined for the reader until a full reload.

Optional Feature:
- Macro SM4_RK_ZEROIZE_EN defined:
  - Adds input port zeroize (1 bit).
  - A zeroize pulse clears all RK_NUM storage words to 0 on the next edge, and behaves as key_load (IDLE, wr_cnt 0, read aborted). It has priority over key_load and all other inputs.
  - rst_n also asynchronously clears the storage array.
- Macro not defined:
  - No zeroize port.
  - Storage is cleared only by overwriting through a full reload.

Test Plan:
- Load: after reset, write rk[i] = 32'hA5A5_0000 | i for i = 0..31 back-to-back -> wr_ready low and key_ready high in the cycle after the 32nd beat; a 33rd wr_valid is ignored.
- Encrypt pass: rd_start with rd_mode=0, rd_ready=1 -> rd_valid from the next cycle for 32 consecutive cycles; rd_rk = 0xA5A50000..0xA5A5001F; rd_idx = 0..31; then one rd_done pulse.
- Decrypt pass with backpressure:
  - Stimulus: rd_mode=1; rd_ready low on every 3rd cycle.
  - Response: rd_rk = 0xA5A5001F down to 0xA5A50000; values and rd_idx held while rd_ready is low; exactly 32 transfers; key_ready stays 1.
- Ignored starts: rd_start in IDLE and during LOAD at wr_cnt=10 -> rd_valid stays 0. A second rd_start mid-READ -> pass unaffected.
- key_load mid-read: pulse at rd_idx=7 in decrypt -> next cycle rd_valid=0, key_ready=0, wr_ready=1, no rd_done. A fresh load of 0x5A5A_0000 | i followed by an encrypt pass -> new values returned.
- Reset mid-load: rst_n low after 12 writes -> all outputs at reset values immediately. After release, a full 32-beat load is required before key_ready rises.
